// File: rtl/sqrt_share_arb.sv
// Shares one pipelined Sqrt2 core among NREQ requesters, routing each result back to its issuer.
// Define SQRT_ARB_PRIO_EN for fixed lowest-index priority; by default arbitration is round-robin.
module sqrt_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 15,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      sq_in,
  input  logic [W-1:0]      sq_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [NREQ-1:0]   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One tag stage shadows the sq_in register, the rest track the core's LAT stages.
  localparam int TS = LAT + 1;

  logic [NREQ-1:0] busy_q, busy_d;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    sq_in_q, sq_in_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [TS-1:0]   tag_vld_q, tag_vld_d;
  logic [IW-1:0]   tag_idx_q [TS];
  logic [IW-1:0]   tag_idx_d [TS];

  assign eligible = req_valid & ~busy_q;

`ifdef SQRT_ARB_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_any = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(off);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!grant_any && eligible[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // The grant is masked while reset is held so no requester sees a handshake.
  assign req_ready = grant & {NREQ{reset}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*W +: W];
      end
    end
  end

  always_comb begin
    sq_in_d      = grant_any ? sel_data : sq_in_q;
    tag_vld_d    = {tag_vld_q[TS-2:0], grant_any};
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < TS; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // A tag leaving the last stage retires its requester on the same edge a new grant may land.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    if (tag_vld_q[TS-1]) begin
      rsp_valid_d[tag_idx_q[TS-1]] = 1'b1;
      rsp_data_d                   = sq_out;
      busy_d[tag_idx_q[TS-1]]      = 1'b0;
    end
    if (grant_any) begin
      busy_d[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_in_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      busy_q      <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < TS; s++) begin
        tag_idx_q[s] <= '0;
      end
`ifndef SQRT_ARB_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      sq_in_q     <= sq_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      tag_vld_q   <= tag_vld_d;
      for (int s = 0; s < TS; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
`ifndef SQRT_ARB_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign sq_in     = sq_in_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Scoreboard bench for sqrt_share_arb with a LAT-stage floor(sqrt) core model.
// Expected responses are queued at issue time and retired by an independent monitor.
module tb_sqrt_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 15;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      sq_in;
  logic [W-1:0]      sq_out;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [NREQ-1:0]   busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NREQ-1:0] vec;
    logic [W-1:0]    data;
    int              due;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  logic [W-1:0] core_pipe [LAT];
  logic [NREQ-1:0] pat [10];

  sqrt_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sq_in     (sq_in),
    .sq_out    (sq_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return W'(r);
  endfunction

  // Stand-in for the Sqrt2 core: LAT registers fed from sq_in.
  initial for (int k = 0; k < LAT; k++) core_pipe[k] = '0;
  always @(posedge clk) begin
    core_pipe[0] <= isqrt(sq_in);
    for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign sq_out = core_pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] vld);
    req_valid = vld;
  endtask

  task automatic setOperand(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic checkReady(input string name, input logic [NREQ-1:0] want);
    #1;
    checkOutput(name, 32'(req_ready), 32'(want));
  endtask

  task automatic expectAccept(input logic [NREQ-1:0] vec, input logic [W-1:0] root);
    exp_t e;
    e.vec  = vec;
    e.data = root;
    e.due  = cyc + LAT + 2;
    expq.push_back(e);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && (expq.size() != 0 || busy != '0); i++) @(negedge clk);
    checkOutput("drain_queue", 32'(expq.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every response must match the oldest outstanding expectation in vector, data and cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (expq.size() > 0 && expq[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_late: got no response, want %0h by cycle %0d (now %0d)",
                 expq[0].vec, expq[0].due, cyc);
        void'(expq.pop_front());
      end
      if (rsp_valid !== '0) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid %0h data %0h, want none (cycle %0d)",
                   rsp_valid, rsp_data, cyc);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("rsp_valid", 32'(rsp_valid), 32'(mon_e.vec));
          checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          checkOutput("rsp_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef SQRT_ARB_PRIO_EN
    pat = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
            4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
`else
    pat = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
            4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
`endif

    // Reset state, with requests held to show that ready stays low.
    applyStimulus(4'b1111);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_sq_in", 32'(sq_in), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    applyStimulus(4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Contention: all four at once, operands 1, 4, 9, 16.
    setOperand(0, 15'd1); setOperand(1, 15'd4); setOperand(2, 15'd9); setOperand(3, 15'd16);
    applyStimulus(4'b1111);
    checkReady("cont_g0", 4'b0001); expectAccept(4'b0001, 15'd1);
    @(negedge clk); applyStimulus(4'b1110);
    checkReady("cont_g1", 4'b0010); expectAccept(4'b0010, 15'd2);
    @(negedge clk); applyStimulus(4'b1100);
    checkReady("cont_g2", 4'b0100); expectAccept(4'b0100, 15'd3);
    @(negedge clk); applyStimulus(4'b1000);
    checkReady("cont_g3", 4'b1000); expectAccept(4'b1000, 15'd4);
    @(negedge clk); applyStimulus(4'b0000);
    checkOutput("cont_sq_in", 32'(sq_in), 32'd16);
    waitDrain();

    // Pointer wrapped to 0: requester 0 must win over requester 3.
    setOperand(0, 15'd49); setOperand(3, 15'd64);
    applyStimulus(4'b1001);
    checkReady("wrap_g0", 4'b0001); expectAccept(4'b0001, 15'd7);
    @(negedge clk); applyStimulus(4'b1000);
    checkReady("wrap_g3", 4'b1000); expectAccept(4'b1000, 15'd8);
    @(negedge clk); applyStimulus(4'b0000);
    waitDrain();

    // Single request, busy window of exactly four cycles.
    setOperand(0, 15'h0190);
    applyStimulus(4'b0001);
    checkReady("single_g0", 4'b0001); expectAccept(4'b0001, 15'h0014);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        applyStimulus(4'b0000);
        checkOutput("single_sq_in", 32'(sq_in), 32'h0190);
      end
      #1;
      checkOutput("single_busy0", 32'(busy[0]), (k < 5) ? 32'd1 : 32'd0);
    end

    // Idle hold for ten cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checkOutput("idle_sq_in", 32'(sq_in), 32'h0190);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("idle_rsp_data", 32'(rsp_data), 32'h0014);
    end
    waitDrain();

    // Busy blocking: requester 2 re-requests immediately and waits for its response cycle.
    setOperand(2, 15'd25);
    applyStimulus(4'b0100);
    checkReady("blk_first", 4'b0100); expectAccept(4'b0100, 15'd5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) setOperand(2, 15'd36);
      checkReady("blk_hold", 4'b0000);
    end
    @(negedge clk);
    checkReady("blk_second", 4'b0100); expectAccept(4'b0100, 15'd6);
    @(negedge clk); applyStimulus(4'b0000);
    waitDrain();

    // Fairness between requesters 0 and 3, both held valid.
    setOperand(0, 15'd100); setOperand(3, 15'd225);
    applyStimulus(4'b1001);
    for (int off = 0; off < 10; off++) begin
      checkReady("fair_grant", pat[off]);
      if (pat[off] != '0) expectAccept(pat[off], (pat[off] == 4'b0001) ? 15'd10 : 15'd15);
      @(negedge clk);
    end
    applyStimulus(4'b0000);
    waitDrain();

    // Reset one cycle after accepting 0x51 from requester 1.
    setOperand(1, 15'h0051);
    applyStimulus(4'b0010);
    checkReady("mid_g1", 4'b0010);
    @(negedge clk);
    applyStimulus(4'b1111);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_sq_in", 32'(sq_in), 32'd0);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_req_ready", 32'(req_ready), 32'd0);
    applyStimulus(4'b0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);

    // Pointer restarted at 0: requester 1 wins over requester 3.
    setOperand(1, 15'd144); setOperand(3, 15'd169);
    applyStimulus(4'b1010);
    checkReady("post_g1", 4'b0010); expectAccept(4'b0010, 15'd12);
    @(negedge clk); applyStimulus(4'b1000);
    checkReady("post_g3", 4'b1000); expectAccept(4'b1000, 15'd13);
    @(negedge clk); applyStimulus(4'b0000);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
